// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled SCL/SDA, fixed 7-bit address, ACKs every
// matched address and written byte, streams read bytes from the fabric.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bus free or not yet seen a START; sda released
// S_ADDR     | shifting in the address byte
// S_ADDR_ACK | address matched; holding sda low through the 9th bit
// S_WR_BYTE  | shifting in a written data byte
// S_WR_ACK   | holding sda low through the 9th bit of a written byte
// S_RD_BYTE  | presenting a read byte, one bit per SCL low phase
// S_RD_ACK   | sda released; sampling the master's ACK/NACK
// S_IGNORE   | not our transfer (or NACKed); wait for START/STOP
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_req,
    output logic       o_addressed,
    output logic       o_rw,
    output logic       o_busy,
    output logic       o_nack_rcvd
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic [7:0]             r_tx_shift;
    logic                   r_sda_low;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_nack;
    logic                   r_addressed;
    logic                   r_rw;
    logic                   r_busy;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;
    logic       w_tx_req;
    logic       w_nack;
    logic       w_byte_done;
    logic       w_addr_hit;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high in both samples so an SCL edge never masquerades as START/STOP
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift, w_sda};

    assign io_sda      = r_sda_low ? 1'b0 : 1'bz;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_tx_req    = w_tx_req & ~i_rst;
    assign o_addressed = r_addressed;
    assign o_rw        = r_rw;
    assign o_busy      = r_busy;
    assign o_nack_rcvd = r_nack;

    // Synchronise the bus lines and keep one history sample for edge detection.
    // Idle-high reset values avoid phantom edges when reset releases.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], io_sda};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and bus-event strobes; START/STOP override bit processing.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_req    = 1'b0;
        w_nack      = 1'b0;
        w_byte_done = 1'b0;
        w_addr_hit  = 1'b0;
        if (w_start) begin
            w_state_nxt = S_ADDR;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_scl_rise) begin
            case (r_state)
                S_ADDR: begin
                    if (r_bit_cnt == 3'd7) begin
                        if (w_byte[7:1] == TARGET_ADDR) begin
                            w_addr_hit  = 1'b1;
                            w_state_nxt = S_ADDR_ACK;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (r_rw) begin
                        w_tx_req    = 1'b1;
                        w_state_nxt = S_RD_BYTE;
                    end else begin
                        w_state_nxt = S_WR_BYTE;
                    end
                end
                S_WR_BYTE: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_byte_done = 1'b1;
                        w_state_nxt = S_WR_ACK;
                    end
                end
                S_WR_ACK:  w_state_nxt = S_WR_BYTE;
                S_RD_BYTE: begin
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_RD_ACK;
                end
                S_RD_ACK: begin
                    if (!w_sda) begin
                        w_tx_req    = 1'b1;
                        w_state_nxt = S_RD_BYTE;
                    end else begin
                        w_nack      = 1'b1;
                        w_state_nxt = S_IGNORE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Datapath: shifters, bit counter, sda drive (updated only after scl_fall) and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_tx_shift  <= 8'd0;
            r_sda_low   <= 1'b0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_nack      <= 1'b0;
            r_addressed <= 1'b0;
            r_rw        <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid <= w_byte_done;
            r_nack     <= w_nack;
            if (w_byte_done) r_rx_data <= w_byte;
            if (w_tx_req)    r_tx_shift <= i_tx_data;

            if (w_start || w_stop) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 7'd0;
                r_sda_low <= 1'b0;
            end else begin
                if (w_scl_rise && (r_state == S_ADDR || r_state == S_WR_BYTE
                                   || r_state == S_RD_BYTE)) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_state != S_RD_BYTE) r_shift <= w_byte[6:0];
                end
                if (w_scl_fall) begin
                    case (r_state)
                        S_ADDR_ACK, S_WR_ACK: r_sda_low <= 1'b1;
                        S_RD_BYTE: begin
                            r_sda_low  <= ~r_tx_shift[7];
                            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                        end
                        default: r_sda_low <= 1'b0;
                    endcase
                end
            end

            if (w_start)     r_busy <= 1'b1;
            else if (w_stop) r_busy <= 1'b0;

            if (w_start || w_stop || w_nack) r_addressed <= 1'b0;
            else if (w_addr_hit)             r_addressed <= 1'b1;

            if (w_addr_hit) r_rw <= w_sda;
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C master drives the bus while a
// transaction-level model predicts ACKs, bus bits, received bytes and pulse counts.
module tb_i2c_target;

    localparam int         QC    = 5;      // clk cycles per quarter SCL period
    localparam logic [6:0] TADDR = 7'h42;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data = 8'd0;
    wire        sda_bus;

    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_tx_req;
    logic       o_addressed;
    logic       o_rw;
    logic       o_busy;
    logic       o_nack_rcvd;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    i2c_target #(.TARGET_ADDR(TADDR), .SYNC_STAGES(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (scl),
        .io_sda      (sda_bus),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .i_tx_data   (tx_data),
        .o_tx_req    (o_tx_req),
        .o_addressed (o_addressed),
        .o_rw        (o_rw),
        .o_busy      (o_busy),
        .o_nack_rcvd (o_nack_rcvd)
    );

    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_rxv   = 0;
    int n_txreq = 0;
    int n_nack  = 0;
    int exp_txreq = 0;
    int exp_nack  = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_q[$];
    logic [7:0] last_tx = 8'd0;
    logic m_busy = 1'b0;
    logic m_addressed = 1'b0;
    logic m_rw = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle checker and fabric: pulse widths, received bytes against the
    // model queue, and tx_data supplied from a queue in each tx_req cycle.
    initial begin
        logic prev_rxv;
        logic prev_nack;
        prev_rxv  = 1'b0;
        prev_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (o_rx_valid) begin
                n_rxv++;
                check("rx_valid_pulse_width", prev_rxv, 0);
                check("rx_valid_expected", exp_rx.size() > 0, 1);
                if (exp_rx.size() > 0) check("rx_data", o_rx_data, exp_rx.pop_front());
            end
            prev_rxv = o_rx_valid;
            if (o_nack_rcvd) begin
                n_nack++;
                check("nack_pulse_width", prev_nack, 0);
            end
            prev_nack = o_nack_rcvd;
            if (o_tx_req) begin
                n_txreq++;
                last_tx = tx_data;
                @(posedge clk);
                #1;
                if (tx_q.size() > 0) void'(tx_q.pop_front());
                tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'd0;
            end
        end
    end

    task automatic q();
        repeat (QC) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_q.push_back(b);
        tx_data = tx_q[0];
    endtask

    // One SCL period; drv=1 releases sda. Returns the bus level mid-high.
    task automatic bit_io(input logic drv, output logic seen);
        m_sda_low = ~drv;
        q(); scl = 1'b1;
        q(); seen = sda_bus;
        q(); scl = 1'b0;
        q();
    endtask

    task automatic start_cond();
        m_sda_low = 1'b0;
        if (!scl) begin
            q(); scl = 1'b1;
        end
        q();
        check("busy_before_start", o_busy, m_busy);
        m_sda_low = 1'b1;
        q(); scl = 1'b0;
        q();
        m_busy = 1'b1;
        m_addressed = 1'b0;
        check("busy_after_start", o_busy, m_busy);
        check("addressed_after_start", o_addressed, m_addressed);
    endtask

    task automatic stop_cond();
        m_sda_low = 1'b1;
        q(); scl = 1'b1;
        q(); m_sda_low = 1'b0;
        q(); q();
        m_busy = 1'b0;
        m_addressed = 1'b0;
        check("busy_after_stop", o_busy, m_busy);
        check("addressed_after_stop", o_addressed, m_addressed);
        check("sda_released_after_stop", sda_bus, 1);
    endtask

    task automatic send_addr(input logic [6:0] a, input logic r);
        logic [7:0] b;
        logic seen;
        logic hit;
        b   = {a, r};
        hit = (a == TADDR);
        if (hit && r) exp_txreq++;
        for (int i = 7; i >= 0; i--) begin
            bit_io(b[i], seen);
            check("addr_bit", seen, b[i]);
        end
        bit_io(1'b1, seen);
        check("addr_ack_level", seen, !hit);
        if (hit) begin
            m_addressed = 1'b1;
            m_rw = r;
        end
        check("addressed", o_addressed, m_addressed);
        check("rw", o_rw, m_rw);
        check("busy", o_busy, m_busy);
    endtask

    task automatic send_data(input logic [7:0] b);
        logic seen;
        logic ack;
        ack = m_addressed && !m_rw;
        if (ack) exp_rx.push_back(b);
        for (int i = 7; i >= 0; i--) begin
            bit_io(b[i], seen);
            check("wr_bit", seen, b[i]);
        end
        bit_io(1'b1, seen);
        check("data_ack_level", seen, !ack);
    endtask

    task automatic recv_data(input logic mack, output logic [7:0] got);
        logic seen;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, seen);
            got[i] = seen;
            check("rd_bit", seen, last_tx[i]);
        end
        bit_io(~mack, seen);
        if (mack) exp_txreq++;
        else begin
            exp_nack++;
            m_addressed = 1'b0;
        end
        check("addressed_after_rd_ack", o_addressed, m_addressed);
    endtask

    task automatic check_counts();
        check("rx_queue_drained", exp_rx.size(), 0);
        check("tx_req_count", n_txreq, exp_txreq);
        check("nack_count", n_nack, exp_nack);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_data"}, o_rx_data, 0);
        check({tag, "_rx_valid"}, o_rx_valid, 0);
        check({tag, "_tx_req"}, o_tx_req, 0);
        check({tag, "_addressed"}, o_addressed, 0);
        check({tag, "_rw"}, o_rw, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_nack"}, o_nack_rcvd, 0);
        check({tag, "_sda"}, sda_bus, 1);
    endtask

    initial begin
        logic [7:0] got;
        logic seen;
        logic [7:0] b;

        repeat (4) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        q();
        check_all_zero("after_reset");

        // Write 0x42+W, 0xA5, STOP
        start_cond();
        send_addr(TADDR, 1'b0);
        send_data(8'hA5);
        check("s1_rx_data", o_rx_data, 8'hA5);
        check("s1_addressed", o_addressed, 1);
        check("s1_rxv_count", n_rxv, 1);
        stop_cond();
        check_counts();

        // Address 0x43+W: ignored
        start_cond();
        send_addr(7'h43, 1'b0);
        send_data(8'h11);
        check("s2_busy", o_busy, 1);
        check("s2_addressed", o_addressed, 0);
        check("s2_rxv_count", n_rxv, 1);
        stop_cond();
        check_counts();

        // Read 0x42+R: 0x3C (ACK), 0xC3 (NACK)
        push_tx(8'h3C);
        push_tx(8'hC3);
        start_cond();
        send_addr(TADDR, 1'b1);
        recv_data(1'b1, got);
        check("s3_byte0_bits", got, 8'h3C);
        recv_data(1'b0, got);
        check("s3_byte1_bits", got, 8'hC3);
        check("s3_addressed", o_addressed, 0);
        check("s3_txreq_count", n_txreq, 2);
        check("s3_nack_count", n_nack, 1);
        stop_cond();
        check_counts();

        // Write 0x5A, repeated START, read 0x81 with NACK, STOP
        push_tx(8'h81);
        start_cond();
        send_addr(TADDR, 1'b0);
        send_data(8'h5A);
        check("s4_rx_data", o_rx_data, 8'h5A);
        check("s4_rw_write", o_rw, 0);
        start_cond();
        send_addr(TADDR, 1'b1);
        check("s4_rw_read", o_rw, 1);
        recv_data(1'b0, got);
        check("s4_read_bits", got, 8'h81);
        check("s4_busy_held", o_busy, 1);
        check("s4_rxv_count", n_rxv, 2);
        check("s4_txreq_count", n_txreq, 3);
        check("s4_nack_count", n_nack, 2);
        stop_cond();
        check_counts();

        // STOP after 4 bits of a write byte
        start_cond();
        send_addr(TADDR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bit_io(1'b1, seen);
            check("s5_partial_bit", seen, 1);
        end
        stop_cond();
        check("s5_rxv_count", n_rxv, 2);
        check_counts();

        // Reset while the address ACK is being driven low
        start_cond();
        b = {TADDR, 1'b0};
        for (int i = 7; i >= 0; i--) begin
            bit_io(b[i], seen);
            check("s6_addr_bit", seen, b[i]);
        end
        m_sda_low = 1'b0;
        q(); scl = 1'b1;
        q();
        check("s6_ack_low_before_rst", sda_bus, 0);
        check("s6_addressed_before_rst", o_addressed, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0;
        m_addressed = 1'b0;
        m_rw = 1'b0;
        check_all_zero("s6_after_rst");
        q(); scl = 1'b0;
        q();
        start_cond();
        send_addr(TADDR, 1'b0);
        send_data(8'h99);
        check("s6_rx_data", o_rx_data, 8'h99);
        check("s6_rxv_count", n_rxv, 3);
        stop_cond();
        check_counts();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
